// File: rtl/arrow_ui_pkg.sv
// rtl/arrow_ui_pkg.sv - shared cursor FSM states, default menu layout and index stepping
package arrow_ui_pkg;

  typedef enum logic {BROWSE, CONFIRM} cursor_state_t;

  localparam logic [9:0] X0_DEF     = 10'd200;
  localparam logic [9:0] Y0_DEF     = 10'd150;
  localparam logic [9:0] Y_STEP_DEF = 10'd40;

  // One-slot move with wrap or saturation at either end of the menu
  function automatic int unsigned step_idx(int unsigned idx, logic dir_down,
                                           int unsigned num_opts, logic wrap);
    if (dir_down)
      return (idx == num_opts - 1) ? (wrap ? 0 : idx) : idx + 1;
    return (idx == 0) ? (wrap ? num_opts - 1 : 0) : idx - 1;
  endfunction

endpackage

// File: rtl/arrow_cursor_ctrl_if.sv
// rtl/arrow_cursor_ctrl_if.sv - glyph anchor and selection handshake between cursor and consumers
interface arrow_cursor_ctrl_if #(
  parameter int NUM_OPTS = 4
);
  localparam int IDX_W = $clog2(NUM_OPTS);

  logic [9:0]       pos_x;
  logic [9:0]       pos_y;
  logic [IDX_W-1:0] cur_idx;
  logic             sel_valid;
  logic             sel_ack;
  logic             blink_on;

  modport master (
    output pos_x, pos_y, cur_idx, sel_valid, blink_on,
    input  sel_ack
  );

  modport slave (
    input  pos_x, pos_y, cur_idx, sel_valid, blink_on,
    output sel_ack
  );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability counter and rising-edge press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      // Any sample agreeing with the accepted level restarts the stability window
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync_2;
        press <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arrow_cursor_ctrl.sv
// rtl/arrow_cursor_ctrl.sv - debounced menu cursor with frame-aligned commit, blink and select handshake
module arrow_cursor_ctrl
  import arrow_ui_pkg::*;
#(
  parameter int         NUM_OPTS        = 4,
  parameter logic [9:0] X0              = X0_DEF,
  parameter logic [9:0] Y0              = Y0_DEF,
  parameter logic [9:0] Y_STEP          = Y_STEP_DEF,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         BLINK_FRAMES    = 30,
  parameter bit         WRAP            = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_sel,
  input  logic frame_tick,
  input  logic enable,
  arrow_cursor_ctrl_if.master cur_if
);

  localparam int IDX_W = $clog2(NUM_OPTS);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [2:0]       btn_level;
  logic             up_press;
  logic             down_press;
  logic             sel_press;
  cursor_state_t    state;
  logic [IDX_W-1:0] pend_idx;
  logic [IDX_W-1:0] cur_idx;
  logic [9:0]       pos_y;
  logic             sel_valid;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .raw(btn_up), .level(btn_level[0]), .press(up_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst_n(rst_n), .raw(btn_down), .level(btn_level[1]), .press(down_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .rst_n(rst_n), .raw(btn_sel), .level(btn_level[2]), .press(sel_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BROWSE;
      pend_idx  <= '0;
      cur_idx   <= '0;
      pos_y     <= Y0;
      sel_valid <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      pos_y <= Y0 + Y_STEP * 10'(cur_idx);
      // Commit samples the pending index before any same-cycle move lands
      if (frame_tick)
        cur_idx <= pend_idx;
      case (state)
        BROWSE: begin
          if (enable && sel_press) begin
            cur_idx   <= pend_idx;
            sel_valid <= 1'b1;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            state     <= CONFIRM;
          end else if (enable && (up_press ^ down_press)) begin
            pend_idx  <= IDX_W'(step_idx(32'(pend_idx), down_press, NUM_OPTS, WRAP));
            blink_cnt <= '0;
            blink_on  <= 1'b1;
          end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        CONFIRM: begin
          blink_on <= 1'b1;
          if (cur_if.sel_ack) begin
            sel_valid <= 1'b0;
            blink_cnt <= '0;
            state     <= BROWSE;
          end
        end
      endcase
    end
  end

  assign cur_if.pos_x     = X0;
  assign cur_if.pos_y     = pos_y;
  assign cur_if.cur_idx   = cur_idx;
  assign cur_if.sel_valid = sel_valid;
  assign cur_if.blink_on  = blink_on;

endmodule

// File: tb/tb_arrow_cursor_ctrl.sv
// tb/tb_arrow_cursor_ctrl.sv - directed self-checking bench for arrow_cursor_ctrl
module tb_arrow_cursor_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_sel = 1'b0;
  logic frame_tick = 1'b0;
  logic enable = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   press_cnt = 0;

  always #5 clk = ~clk;

  arrow_cursor_ctrl_if #(.NUM_OPTS(4)) cif ();
  arrow_cursor_ctrl_if #(.NUM_OPTS(4)) cif_sat ();

  arrow_cursor_ctrl #(
    .NUM_OPTS(4), .X0(10'd200), .Y0(10'd150), .Y_STEP(10'd40),
    .DEBOUNCE_CYCLES(4), .BLINK_FRAMES(3), .WRAP(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .frame_tick(frame_tick), .enable(enable), .cur_if(cif.master)
  );

  arrow_cursor_ctrl #(
    .NUM_OPTS(4), .X0(10'd200), .Y0(10'd150), .Y_STEP(10'd40),
    .DEBOUNCE_CYCLES(4), .BLINK_FRAMES(3), .WRAP(1'b0)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .frame_tick(frame_tick), .enable(enable), .cur_if(cif_sat.master)
  );

  always @(posedge clk)
    if (dut.up_press || dut.down_press || dut.sel_press) press_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    frame_tick = 1'b0; enable = 1'b1;
    cif.sel_ack = 1'b0; cif_sat.sel_ack = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic press_btn(input logic [2:0] mask);
    btn_up = mask[0]; btn_down = mask[1]; btn_sel = mask[2];
    step(10);
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    step(10);
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cif.pos_x !== 10'd200) begin failures++; $display("FAIL reset_pos_x got=%0d exp=200", cif.pos_x); end
    checks++; if (cif.pos_y !== 10'd150) begin failures++; $display("FAIL reset_pos_y got=%0d exp=150", cif.pos_y); end
    checks++; if (cif.cur_idx !== 2'd0) begin failures++; $display("FAIL reset_cur_idx got=%0d exp=0", cif.cur_idx); end
    checks++; if (cif.sel_valid !== 1'b0) begin failures++; $display("FAIL reset_sel_valid got=%b exp=0", cif.sel_valid); end
    checks++; if (cif.blink_on !== 1'b1) begin failures++; $display("FAIL reset_blink_on got=%b exp=1", cif.blink_on); end
    checks++; if (cif_sat.pos_y !== 10'd150) begin failures++; $display("FAIL reset_sat_pos_y got=%0d exp=150", cif_sat.pos_y); end
  endtask

  task automatic test_down_press();
    int base;
    int lat;
    do_reset();
    base = press_cnt;
    lat = 0;
    btn_down = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step(1);
      if (dut.down_press === 1'b1) lat = i;
    end
    checks++; if (lat != 6) begin failures++; $display("FAIL down_latency got=%0d exp=6", lat); end
    step(1);
    checks++; if (dut.down_press !== 1'b0) begin failures++; $display("FAIL down_pulse_width got=%b exp=0", dut.down_press); end
    step(3);
    btn_down = 1'b0;
    step(10);
    checks++; if (press_cnt - base != 1) begin failures++; $display("FAIL down_press_count got=%0d exp=1", press_cnt - base); end
    checks++; if (cif.cur_idx !== 2'd0) begin failures++; $display("FAIL down_before_tick got=%0d exp=0", cif.cur_idx); end
    pulse_frame();
    checks++; if (cif.cur_idx !== 2'd1) begin failures++; $display("FAIL down_cur_idx got=%0d exp=1", cif.cur_idx); end
    checks++; if (cif.pos_y !== 10'd150) begin failures++; $display("FAIL down_pos_y_tick1 got=%0d exp=150", cif.pos_y); end
    step(1);
    checks++; if (cif.pos_y !== 10'd190) begin failures++; $display("FAIL down_pos_y_tick2 got=%0d exp=190", cif.pos_y); end
  endtask

  task automatic test_bounce();
    int hi [6] = '{1, 2, 3, 1, 2, 3};
    int lo [6] = '{2, 1, 2, 1, 3, 2};
    int base;
    int bad;
    do_reset();
    base = press_cnt;
    for (int i = 0; i < 6; i++) begin
      btn_down = 1'b1; step(hi[i]);
      btn_down = 1'b0; step(lo[i]);
    end
    step(10);
    checks++; if (press_cnt != base) begin failures++; $display("FAIL bounce_press_count got=%0d exp=0", press_cnt - base); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      step(1);
      if (cif.cur_idx !== 2'd0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bounce_cur_idx got=%0d exp=0 bad_ticks=%0d", cif.cur_idx, bad); end
  endtask

  task automatic test_wrap();
    do_reset();
    press_btn(3'b001);
    pulse_frame();
    step(1);
    checks++; if (cif.cur_idx !== 2'd3) begin failures++; $display("FAIL wrap_cur_idx got=%0d exp=3", cif.cur_idx); end
    checks++; if (cif.pos_y !== 10'd270) begin failures++; $display("FAIL wrap_pos_y got=%0d exp=270", cif.pos_y); end
    checks++; if (cif_sat.cur_idx !== 2'd0) begin failures++; $display("FAIL sat_cur_idx got=%0d exp=0", cif_sat.cur_idx); end
    checks++; if (cif_sat.pos_y !== 10'd150) begin failures++; $display("FAIL sat_pos_y got=%0d exp=150", cif_sat.pos_y); end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    press_btn(3'b010);
    press_btn(3'b100);
    enable = 1'b1;
    pulse_frame();
    checks++; if (cif.cur_idx !== 2'd0) begin failures++; $display("FAIL enable_cur_idx got=%0d exp=0", cif.cur_idx); end
    checks++; if (cif.sel_valid !== 1'b0) begin failures++; $display("FAIL enable_sel_valid got=%b exp=0", cif.sel_valid); end
  endtask

  task automatic test_sel_confirm();
    int bad;
    do_reset();
    press_btn(3'b010);
    press_btn(3'b010);
    pulse_frame();
    checks++; if (cif.cur_idx !== 2'd2) begin failures++; $display("FAIL sel_setup_idx got=%0d exp=2", cif.cur_idx); end
    press_btn(3'b110);
    checks++; if (cif.sel_valid !== 1'b1) begin failures++; $display("FAIL sel_valid_set got=%b exp=1", cif.sel_valid); end
    checks++; if (cif.cur_idx !== 2'd2) begin failures++; $display("FAIL sel_cur_idx got=%0d exp=2", cif.cur_idx); end
    press_btn(3'b001);
    press_btn(3'b010);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      pulse_frame();
      step(1);
      if (cif.blink_on !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL confirm_blink got_low_ticks=%0d exp=0", bad); end
    checks++; if (cif.sel_valid !== 1'b1) begin failures++; $display("FAIL confirm_held got=%b exp=1", cif.sel_valid); end
    checks++; if (cif.cur_idx !== 2'd2) begin failures++; $display("FAIL confirm_idx got=%0d exp=2", cif.cur_idx); end
    cif.sel_ack = 1'b1;
    checks++; if (cif.sel_valid !== 1'b1) begin failures++; $display("FAIL ack_same_cycle got=%b exp=1", cif.sel_valid); end
    step(1);
    cif.sel_ack = 1'b0;
    checks++; if (cif.sel_valid !== 1'b0) begin failures++; $display("FAIL ack_clear got=%b exp=0", cif.sel_valid); end
    pulse_frame();
    checks++; if (cif.cur_idx !== 2'd2) begin failures++; $display("FAIL ack_idx got=%0d exp=2", cif.cur_idx); end
  endtask

  task automatic test_blink();
    logic exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp2 [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pulse_frame();
      step(1);
      checks++; if (cif.blink_on !== exp[i]) begin failures++; $display("FAIL blink_tick%0d got=%b exp=%b", i + 1, cif.blink_on, exp[i]); end
    end
    pulse_frame(); step(1);
    pulse_frame(); step(1);
    press_btn(3'b010);
    checks++; if (cif.blink_on !== 1'b1) begin failures++; $display("FAIL blink_after_move got=%b exp=1", cif.blink_on); end
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      step(1);
      checks++; if (cif.blink_on !== exp2[i]) begin failures++; $display("FAIL blink_restart%0d got=%b exp=%b", i + 1, cif.blink_on, exp2[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    press_btn(3'b100);
    checks++; if (cif.sel_valid !== 1'b1) begin failures++; $display("FAIL rstmid_confirm got=%b exp=1", cif.sel_valid); end
    btn_down = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    checks++; if (cif.sel_valid !== 1'b0) begin failures++; $display("FAIL rstmid_sel_valid got=%b exp=0", cif.sel_valid); end
    checks++; if (cif.pos_y !== 10'd150) begin failures++; $display("FAIL rstmid_pos_y got=%0d exp=150", cif.pos_y); end
    checks++; if (cif.blink_on !== 1'b1) begin failures++; $display("FAIL rstmid_blink got=%b exp=1", cif.blink_on); end
    btn_down = 1'b0;
    step(2);
    rst_n = 1'b1;
    base = press_cnt;
    step(20);
    checks++; if (press_cnt != base) begin failures++; $display("FAIL rstmid_spurious got=%0d exp=0", press_cnt - base); end
    pulse_frame();
    step(1);
    checks++; if (cif.cur_idx !== 2'd0) begin failures++; $display("FAIL rstmid_cur_idx got=%0d exp=0", cif.cur_idx); end
    checks++; if (cif.pos_y !== 10'd150) begin failures++; $display("FAIL rstmid_pos_y_after got=%0d exp=150", cif.pos_y); end
  endtask

  initial begin
    cif.sel_ack = 1'b0;
    cif_sat.sel_ack = 1'b0;
    test_reset();
    test_down_press();
    test_bounce();
    test_wrap();
    test_enable();
    test_sel_confirm();
    test_blink();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
